// File: rtl/bwt_byte_reader.sv
// Word-to-byte unpacker: buffers 32-bit words in a small FIFO and emits them
// LSB-first as a byte stream, honouring a partial byte count on the last word of a block.
module bwt_byte_reader #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic                       in_last,
    input  logic [1:0]                 in_nbytes,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_byte,
    output logic                       out_last,
    output logic                       block_done,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_EMIT  = 1'b1;

    logic [31:0]   mem_data   [DEPTH];
    logic          mem_last   [DEPTH];
    logic [1:0]    mem_nbytes [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          state;
    logic [1:0]    bidx;

    logic [31:0]   head_data;
    logic          head_last;
    logic [1:0]    head_nbytes;
    logic [1:0]    last_idx;
    logic [31:0]   head_shifted;
    logic          emit;
    logic          byte_final;
    logic          accept;
    logic          push;
    logic          pop;

    assign head_data   = mem_data[rptr];
    assign head_last   = mem_last[rptr];
    assign head_nbytes = mem_nbytes[rptr];

    // Index of the head word's final byte (hcnt-1); nbytes=0 on a last word means all four.
    assign last_idx     = (head_last && head_nbytes != 2'd0) ? head_nbytes - 2'd1 : 2'd3;
    assign head_shifted = head_data >> {bidx, 3'b000};

    assign emit       = (state == ST_EMIT);
    assign byte_final = (bidx == last_idx);
    assign accept     = emit && out_ready;
    assign in_ready   = (count != FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign pop        = accept && byte_final;

    assign out_valid = emit;
    assign out_byte  = emit ? head_shifted[7:0] : 8'h00;
    assign out_last  = emit && head_last && byte_final;
    assign level     = count;

    // NOTE: the storage array has no reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr]   <= in_data;
            mem_last[wptr]   <= in_last;
            mem_nbytes[wptr] <= in_nbytes;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            state      <= ST_EMPTY;
            bidx       <= 2'd0;
            block_done <= 1'b0;
        end else begin
            block_done <= accept && head_last && byte_final;

            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            if (accept) bidx <= byte_final ? 2'd0 : bidx + 2'd1;

            case (state)
                ST_EMPTY: if (push) state <= ST_EMIT;
                default:  if (pop && !push && count == (AW + 1)'(1)) state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_bwt_byte_reader.sv
// Self-checking bench for bwt_byte_reader: a byte-queue reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bwt_byte_reader;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic [1:0]    in_nbytes = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_byte;
    logic          out_last;
    logic          block_done;
    logic [LW-1:0] level;

    bwt_byte_reader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .block_done(block_done), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic       wend;
    } exp_byte_t;

    exp_byte_t   exp_q[$];
    logic        exp_bd = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  got_b[$];
    logic        got_l[$];
    int          got_c[$];
    int          push_c[$];
    logic        throttle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int words_held();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].wend) n++;
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected bytes in order; checked and advanced once per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_bd = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_level", level, 0);
            check("rst_block_done", block_done, 0);
            check("rst_out_byte", out_byte, 0);
        end else begin
            int  held;
            logic exp_valid, exp_ready, acc, psh, bd_next;
            held      = words_held();
            exp_valid = (exp_q.size() != 0);
            exp_ready = (held < DEPTH);
            check("out_valid", out_valid, exp_valid);
            check("in_ready", in_ready, exp_ready);
            check("level", level, held);
            check("block_done", block_done, exp_bd);
            if (exp_valid) begin
                check("out_byte", out_byte, exp_q[0].b);
                check("out_last", out_last, exp_q[0].last);
            end else begin
                check("out_last_idle", out_last, 0);
            end
            acc     = exp_valid && out_ready;
            psh     = in_valid && exp_ready;
            bd_next = acc && exp_q[0].last;
            if (acc) begin
                got_b.push_back(exp_q[0].b);
                got_l.push_back(out_last);
                got_c.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (psh) begin
                int n;
                n = (in_last && in_nbytes != 2'd0) ? int'(in_nbytes) : 4;
                push_c.push_back(cyc);
                for (int i = 0; i < n; i++) begin
                    exp_byte_t e;
                    e.b    = 8'((in_data >> (8 * i)) & 32'hFF);
                    e.last = in_last && (i == n - 1);
                    e.wend = (i == n - 1);
                    exp_q.push_back(e);
                end
            end
            exp_bd = bd_next;
        end
    end

    task automatic clear_logs();
        got_b.delete(); got_l.delete(); got_c.delete(); push_c.delete();
    endtask

    // Leaves in_valid asserted so back-to-back calls form a continuous stream.
    task automatic push_word(input logic [31:0] d, input logic l, input logic [1:0] nb);
        logic ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l; in_nbytes = nb;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (throttle) out_ready = 1'($urandom_range(0, 1));
            if (ok) break;
        end
        check("push_timeout", ok, 1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_timeout", exp_q.size(), 0);
    endtask

    logic [7:0] exp_bytes[$];
    logic [7:0] held_byte;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Two-word block, full last word.
        clear_logs();
        out_ready = 1'b1;
        push_word(32'h44332211, 1'b0, 2'd0);
        push_word(32'h88776655, 1'b1, 2'd0);
        drain();
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        check("t1_count", got_b.size(), 8);
        foreach (exp_bytes[i]) if (i < got_b.size()) begin
            check("t1_byte", got_b[i], exp_bytes[i]);
            check("t1_last", got_l[i], (i == 7) ? 1 : 0);
            check("t1_consecutive", got_c[i], got_c[0] + i);
        end
        check("t1_latency", got_c[0], push_c[0] + 1);

        // Partial last word followed immediately by a one-byte block.
        clear_logs();
        push_word(32'hDDCCBBAA, 1'b1, 2'd3);
        push_word(32'h00000001, 1'b1, 2'd1);
        drain();
        exp_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'h01};
        check("t2_count", got_b.size(), 4);
        foreach (exp_bytes[i]) if (i < got_b.size()) begin
            check("t2_byte", got_b[i], exp_bytes[i]);
            check("t2_last", got_l[i], (i >= 2) ? 1 : 0);
            check("t2_consecutive", got_c[i], got_c[0] + i);
        end

        // Fill with out_ready low, then try to overfill.
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push_word(32'h10203040 + i * 32'h01010101, 1'b0, 2'd0);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
        @(negedge clk);
        check("t3_level_full", level, DEPTH);
        check("t3_in_ready_full", in_ready, 0);
        check("t3_head_byte", out_byte, 8'h40);
        held_byte = out_byte;
        repeat (3) @(negedge clk);
        check("t3_level_held", level, DEPTH);
        check("t3_byte_held", out_byte, held_byte);
        @(posedge clk); #1;
        drain();
        check("t3_count", got_b.size(), 4 * DEPTH);
        for (int i = 0; i < 4 * DEPTH && i < got_b.size(); i++)
            check("t3_byte", got_b[i], 8'(((32'h10203040 + (i / 4) * 32'h01010101) >> (8 * (i % 4))) & 32'hFF));

        // Throttled continuous stream across several pointer wraps.
        clear_logs();
        throttle = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 5; i++)
            push_word($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        throttle = 1'b0;
        drain();

        // Simultaneous push and pop with two words held.
        clear_logs();
        out_ready = 1'b0;
        push_word(32'h04030201, 1'b0, 2'd0);
        push_word(32'h08070605, 1'b0, 2'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 32'h0C0B0A09; in_last = 1'b1; in_nbytes = 2'd0;
        @(negedge clk);
        check("t5_level_before", level, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_level_after", level, 2);
        drain();
        check("t5_count", got_b.size(), 12);
        for (int i = 0; i < 12 && i < got_b.size(); i++)
            check("t5_byte", got_b[i], 8'(i + 1));

        // Reset mid-word, then a fresh word.
        out_ready = 1'b1;
        push_word(32'h44332211, 1'b0, 2'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_level", level, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_out_byte", out_byte, 0);
        check("t6_out_last", out_last, 0);
        @(posedge clk); #1 rst = 1'b1;
        clear_logs();
        push_word(32'hA5A5A5A5, 1'b1, 2'd0);
        drain();
        check("t6_count", got_b.size(), 4);
        foreach (got_b[i]) check("t6_byte", got_b[i], 8'hA5);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bwt_byte_reader.md
# bwt_byte_reader

Read-side companion to the 32-bit word input buffer. It accepts 32-bit words from the transform datapath over a valid/ready handshake, stores them in a small word FIFO, and unpacks them into a byte stream, least-significant byte first. The final word of a block may carry 1–4 valid bytes, and the last byte emitted is flagged. It sits between the transform core output and the byte-wide output port.

## Interface
- `DEPTH`, default 4: word FIFO depth. Must be a power of two, ≥ 2.
- `clk`  input  1  clock. All state changes on the rising edge.
- `rst`  input  1  reset. Asynchronous and active-low: rst=0 clears all state immediately.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  space available. Equals `!full`.
- `in_data`  input  32  word. Byte 0 is `in_data[7:0]`.
- `in_last`  input  1  marks this word as the final word of a block.
- `in_nbytes`  input  2  valid bytes in a last word. 1, 2 or 3 select that many bytes; 0 selects 4. Ignored when `in_last`=0.
- `out_valid`  output  1  `out_byte` valid.
- `out_ready`  input  1  downstream accepts byte.
- `out_byte`  output  8  current byte.
- `out_last`  output  1  current byte is the final byte of the block.
- `block_done`  output  1  one-cycle pulse, registered, after the last byte of a block is accepted.
- `level`  output  $clog2(DEPTH)+1  number of words held.

## Operation
- Each FIFO entry stores {data[31:0], last, nbytes[1:0]}. The write pointer, read pointer and count are registered.
- Push happens when `in_valid && in_ready`. Pop happens when the head word's final byte is accepted.
- A byte index register `bidx` (2 bits) selects the head byte: `out_byte = head.data[8*bidx +: 8]`.
- Head byte count `hcnt` = 4 if `head.last`=0 or `head.nbytes`=0; otherwise `hcnt` = `head.nbytes`.
- Two-state FSM:
  - EMPTY: `out_valid`=0. Move to EMIT when `count` becomes non-zero.
  - EMIT: `out_valid`=1. On accept (`out_valid && out_ready`):
    - if `bidx` = `hcnt`-1: pop, set `bidx` to 0, and move to EMPTY if the FIFO is now empty;
    - otherwise increment `bidx`.
- `out_last = head.last && (bidx == hcnt-1)` while in EMIT; 0 otherwise.
- `block_done` is set on the edge that accepts a byte with `out_last`=1. It is cleared on the following edge.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full: `in_ready`=0 even if a pop occurs that cycle. There is no write bypass into a freed slot.
- Pointers wrap modulo `DEPTH`.
- Bytes above `nbytes` in a last word are never emitted. Their contents are don't-care.
- A new block may follow immediately. The word after a last word starts at `bidx`=0, with no gap.
- `out_ready` held low: `out_byte`, `out_last` and `bidx` are held stable.

## Timing
- Reset values (rst=0): `in_ready`=1, `out_valid`=0, `out_byte`=0x00, `out_last`=0, `block_done`=0, `level`=0, FSM=EMPTY, `bidx`=0, pointers=0.
- Latency: a word pushed on edge k produces `out_valid`=1 after edge k, so the first byte is acceptable at edge k+1.
- Throughput: 1 byte per cycle with `out_ready` held high. A 4-byte word occupies the head for 4 accepting edges.
- Reset asserted mid-block: all words and the partial byte index are discarded at once. After release the block behaves as freshly reset. The first rising edge with rst=1 is a normal cycle.
- `out_byte` and `out_last` are combinational from the head entry and `bidx`. `block_done` and `level` are registered.

## Test plan
- Reset, then push 0x44332211 (last=0) and 0x88776655 (last=1, nbytes=0), with `out_ready`=1 → 11,22,33,44,55,66,77,88 on consecutive cycles. `out_last`=1 only on 88. `block_done` pulses one cycle later.
- Push 0xDDCCBBAA with last=1, nbytes=3 → bytes AA,BB,CC only, `out_last` on CC. Then push 0x00000001 (last=1, nbytes=1) → 01 with `out_last`=1, with no idle cycle in between.
- Hold `out_ready`=0 and push DEPTH words → `level`=DEPTH and `in_ready`=0. A further push is refused, and the FIFO contents and `out_byte` stay unchanged. Release → all 4·DEPTH bytes arrive in order.
- Random `out_ready` throttling with a continuous `in_valid` stream across more than 3·DEPTH words (pointer wrap) → byte stream matches the reference model exactly, with `level` never above DEPTH.
- Simultaneous push and pop at `level`=2 → `level` remains 2 and ordering is preserved.
- Assert rst=0 mid-word after 2 bytes of 0x44332211 → outputs take reset values immediately. Push 0xA5A5A5A5 after release → A5 ×4, no residue from the aborted word.
